// File: rtl/des_key_sched_ctrl.sv
// Sequences the DES subkey generator: loads a new key/mode, waits for trustworthy
// subkeys, then hands out one-cycle block-start grants to the round core.
module des_key_sched_ctrl #(
  parameter int EN_CYCLES    = 2,
  parameter int TIMEOUT      = 32,
  parameter int PARITY_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_req_valid,
  output logic        key_req_ready,
  input  logic [63:0] key_req_key,
  input  logic        key_req_encrypt,
  output logic        gen_key_en,
  output logic [63:0] gen_key,
  output logic        gen_encrypt,
  input  logic        gen_subkeys_valid,
  input  logic        gen_parity_error,
  input  logic        blk_req,
  output logic        blk_grant,
  input  logic        core_busy,
  output logic        key_ready,
  output logic [1:0]  key_err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DRAIN, ST_LOAD, ST_WAIT, ST_READY, ST_ERROR
  } state_t;

  localparam logic [3:0] EN_LAST     = 4'(EN_CYCLES);
  localparam logic [7:0] TO_LAST     = 8'(TIMEOUT - 1);
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  state_t      state, state_nxt;
  logic [3:0]  en_cnt, en_cnt_nxt;
  logic [7:0]  to_cnt, to_cnt_nxt;
  logic        seen_low, seen_low_nxt;
  logic        key_en_nxt, grant_nxt, key_ready_nxt;
  logic [1:0]  key_err_nxt;
  logic        load_from_req, load_from_pend;
  logic        accept;
  logic [63:0] pend_key;
  logic        pend_enc;

  assign key_req_ready = (state == ST_IDLE) || (state == ST_READY) || (state == ST_ERROR);
  assign accept        = key_req_valid && key_req_ready;

  always_comb begin
    state_nxt      = state;
    en_cnt_nxt     = en_cnt;
    to_cnt_nxt     = to_cnt;
    seen_low_nxt   = seen_low;
    key_en_nxt     = 1'b0;
    grant_nxt      = 1'b0;
    key_ready_nxt  = key_ready;
    key_err_nxt    = key_err;
    load_from_req  = 1'b0;
    load_from_pend = 1'b0;
    case (state)
      ST_IDLE, ST_ERROR: begin
        if (accept) begin
          key_err_nxt   = ERR_NONE;
          key_ready_nxt = 1'b0;
          if (!core_busy) begin
            state_nxt     = ST_LOAD;
            load_from_req = 1'b1;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!core_busy) begin
          state_nxt      = ST_LOAD;
          load_from_pend = 1'b1;
        end
      end
      ST_LOAD: begin
        seen_low_nxt = seen_low || !gen_subkeys_valid;
        if (en_cnt == EN_LAST) begin
          state_nxt  = ST_WAIT;
          to_cnt_nxt = 8'd0;
        end else begin
          en_cnt_nxt = en_cnt + 4'd1;
          key_en_nxt = 1'b1;
        end
      end
      ST_WAIT: begin
        seen_low_nxt = seen_low || !gen_subkeys_valid;
        // Valid only counts once it has been seen low since this load began.
        if (seen_low && gen_subkeys_valid) begin
          if ((PARITY_CHECK != 0) && gen_parity_error) begin
            state_nxt   = ST_ERROR;
            key_err_nxt = ERR_PARITY;
          end else begin
            state_nxt     = ST_READY;
            key_ready_nxt = 1'b1;
          end
        end else if (to_cnt == TO_LAST) begin
          state_nxt   = ST_ERROR;
          key_err_nxt = ERR_TIMEOUT;
        end else begin
          to_cnt_nxt = to_cnt + 8'd1;
        end
      end
      ST_READY: begin
        if (accept) begin
          state_nxt     = ST_DRAIN;
          key_err_nxt   = ERR_NONE;
          key_ready_nxt = 1'b0;
        end else if (!gen_subkeys_valid) begin
          state_nxt     = ST_WAIT;
          key_ready_nxt = 1'b0;
          seen_low_nxt  = 1'b1;
          to_cnt_nxt    = 8'd0;
        end else begin
          grant_nxt = blk_req && !core_busy && !blk_grant;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (load_from_req || load_from_pend) begin
      en_cnt_nxt   = 4'd1;
      key_en_nxt   = 1'b1;
      seen_low_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      en_cnt     <= 4'd0;
      to_cnt     <= 8'd0;
      seen_low   <= 1'b0;
      gen_key_en <= 1'b0;
      blk_grant  <= 1'b0;
      key_ready  <= 1'b0;
      key_err    <= ERR_NONE;
    end else begin
      state      <= state_nxt;
      en_cnt     <= en_cnt_nxt;
      to_cnt     <= to_cnt_nxt;
      seen_low   <= seen_low_nxt;
      gen_key_en <= key_en_nxt;
      blk_grant  <= grant_nxt;
      key_ready  <= key_ready_nxt;
      key_err    <= key_err_nxt;
    end
  end

  // gen_key only moves on a LOAD entry edge, which is never taken while core_busy=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_key     <= 64'd0;
      gen_encrypt <= 1'b1;
    end else if (load_from_req) begin
      gen_key     <= key_req_key;
      gen_encrypt <= key_req_encrypt;
    end else if (load_from_pend) begin
      gen_key     <= pend_key;
      gen_encrypt <= pend_enc;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_key <= key_req_key;
      pend_enc <= key_req_encrypt;
    end
  end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Bench for des_key_sched_ctrl: table of key requests against a behavioural
// subkey-generator model, plus grant, valid-drop and async-reset sequences.
module tb_des_key_sched_ctrl;
  localparam int EN_CYCLES = 2;
  localparam int TIMEOUT   = 32;
  localparam int GEN_T     = 19;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_req_valid, key_req_ready, key_req_encrypt;
  logic [63:0] key_req_key, gen_key;
  logic        gen_key_en, gen_encrypt, gen_subkeys_valid, gen_parity_error;
  logic        blk_req, blk_grant, core_busy, key_ready;
  logic [1:0]  key_err;

  always #5 clk = ~clk;

  des_key_sched_ctrl #(.EN_CYCLES(EN_CYCLES), .TIMEOUT(TIMEOUT), .PARITY_CHECK(1)) dut (
    .clk(clk), .rst(rst),
    .key_req_valid(key_req_valid), .key_req_ready(key_req_ready),
    .key_req_key(key_req_key), .key_req_encrypt(key_req_encrypt),
    .gen_key_en(gen_key_en), .gen_key(gen_key), .gen_encrypt(gen_encrypt),
    .gen_subkeys_valid(gen_subkeys_valid), .gen_parity_error(gen_parity_error),
    .blk_req(blk_req), .blk_grant(blk_grant), .core_busy(core_busy),
    .key_ready(key_ready), .key_err(key_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // DES keys carry odd parity in every byte.
  function automatic bit bad_parity(input logic [63:0] k);
    for (int b = 0; b < 8; b++)
      if ((^k[b*8 +: 8]) == 1'b0) return 1'b1;
    return 1'b0;
  endfunction

  // Subkey generator model: valid drops after a load (unless stale), rises GEN_T cycles later.
  int   age = 1000;
  bit   gen_loaded = 1'b0, gen_never = 1'b0, gen_force_low = 1'b0;
  int   gen_stale = 0;
  logic prev_en = 1'b0;

  initial begin
    gen_subkeys_valid = 1'b0;
    gen_parity_error  = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (gen_key_en && !prev_en) begin
        age = 0;
        gen_loaded = 1'b1;
      end else if (age < 1000) begin
        age++;
      end
      prev_en = gen_key_en;
      gen_subkeys_valid = gen_loaded && !gen_force_low &&
                          ((age < gen_stale) || (!gen_never && age >= GEN_T));
      gen_parity_error  = gen_subkeys_valid && bad_parity(gen_key);
    end
  end

  typedef struct {
    logic [63:0] key;
    logic        enc;
    int          busy;
    int          stale;
    bit          never;
    logic [1:0]  err;
  } row_t;

  row_t        rows[7];
  logic [63:0] model_gk = 64'd0;

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 64'(key_req_ready), 64'd1);
    check({tag, "_key_en"},    64'(gen_key_en),    64'd0);
    check({tag, "_gen_key"},   gen_key,            64'd0);
    check({tag, "_gen_enc"},   64'(gen_encrypt),   64'd1);
    check({tag, "_grant"},     64'(blk_grant),     64'd0);
    check({tag, "_key_ready"}, 64'(key_ready),     64'd0);
    check({tag, "_key_err"},   64'(key_err),       64'd0);
  endtask

  task automatic run_row(input row_t r);
    int cyc, en_seen;
    bit started, done;
    @(negedge clk);
    gen_stale = r.stale;
    gen_never = r.never;
    key_req_valid = 1'b1; key_req_key = r.key; key_req_encrypt = r.enc;
    blk_req = 1'b1; core_busy = (r.busy > 0);
    check("row_req_ready", 64'(key_req_ready), 64'd1);
    @(negedge clk);
    key_req_valid = 1'b0;
    check("row_req_beats_blk", 64'(blk_grant), 64'd0);
    check("row_ready_drop", 64'(key_ready), 64'd0);
    check("row_err_clear", 64'(key_err), 64'd0);
    for (int i = 0; i < r.busy; i++) begin
      check("busy_key_hold", gen_key, model_gk);
      check("busy_req_ready", 64'(key_req_ready), 64'd0);
      check("busy_no_en", 64'(gen_key_en), 64'd0);
      check("busy_no_grant", 64'(blk_grant), 64'd0);
      if (i == r.busy - 1) core_busy = 1'b0;
      @(negedge clk);
    end
    blk_req = 1'b0; core_busy = 1'b0;
    cyc = 0; en_seen = 0; started = 1'b0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (gen_key_en && !started) begin started = 1'b1; cyc = 0; end
      else if (started) cyc++;
      if (gen_key_en) en_seen++;
      if (started && (key_ready || key_err != 2'b00)) done = 1'b1;
      else @(negedge clk);
    end
    check("row_done", 64'(done), 64'd1);
    check("row_en_cycles", 64'(en_seen), 64'(EN_CYCLES));
    check("row_latency", 64'(cyc), (r.err == 2'b10) ? 64'(EN_CYCLES + TIMEOUT) : 64'(GEN_T + 1));
    check("row_key_err", 64'(key_err), 64'(r.err));
    check("row_key_ready", 64'(key_ready), 64'(r.err == 2'b00));
    check("row_gen_key", gen_key, r.key);
    check("row_gen_enc", 64'(gen_encrypt), 64'(r.enc));
    model_gk = r.key;
    if (r.err != 2'b00) begin
      blk_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("err_no_grant", 64'(blk_grant), 64'd0);
        check("err_held", 64'(key_err), 64'(r.err));
      end
      blk_req = 1'b0;
    end
  endtask

  // held=1: blk_req stuck high while core_busy toggles; held=0: both random.
  task automatic grant_phase(input int n, input bit held);
    logic exp_g, rq, bz;
    exp_g = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("grant", 64'(blk_grant), 64'(exp_g));
      rq = held ? 1'b1 : 1'($urandom_range(0, 1));
      bz = held ? 1'(((i / 3) % 2)) : 1'($urandom_range(0, 1));
      blk_req = rq; core_busy = bz;
      exp_g = rq && !bz && !exp_g;
    end
    @(negedge clk);
    check("grant_last", 64'(blk_grant), 64'(exp_g));
    blk_req = 1'b0; core_busy = 1'b0;
    @(negedge clk);
    check("grant_idle", 64'(blk_grant), 64'd0);
  endtask

  initial begin
    row_t rr;
    logic [63:0] k;
    rows[0] = '{64'h133457799BBCDFF1, 1'b1, 0,  0, 1'b0, 2'b00};
    rows[1] = '{64'h0E329232EA6D0D73, 1'b0, 10, 0, 1'b0, 2'b00};
    rows[2] = '{64'h0123456789ABCDEF, 1'b1, 0,  EN_CYCLES + 2, 1'b0, 2'b00};
    rows[3] = '{64'h133457799BBCDFF0, 1'b1, 2,  0, 1'b0, 2'b01};
    rows[4] = '{64'h0123456789ABCDEF, 1'b0, 0,  0, 1'b0, 2'b00};
    rows[5] = '{64'h0E329232EA6D0D73, 1'b1, 0,  0, 1'b1, 2'b10};
    rows[6] = '{64'h133457799BBCDFF1, 1'b0, 3,  0, 1'b0, 2'b00};

    key_req_valid = 1'b0; key_req_key = 64'd0; key_req_encrypt = 1'b0;
    blk_req = 1'b0; core_busy = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (rows[i]) run_row(rows[i]);

    grant_phase(24, 1'b1);
    grant_phase(40, 1'b0);

    // Subkeys-valid glitch in READY: back to WAIT, then straight back to READY.
    @(negedge clk);
    gen_force_low = 1'b1;
    @(negedge clk);
    check("drop_ready_low", 64'(key_ready), 64'd0);
    gen_force_low = 1'b0;
    @(negedge clk);
    check("drop_ready_back", 64'(key_ready), 64'd1);
    check("drop_no_err", 64'(key_err), 64'd0);

    for (int it = 0; it < 6; it++) begin
      k = {$urandom, $urandom};
      if (it % 2 == 0)
        for (int b = 0; b < 8; b++) k[b*8] = ~^k[b*8+1 +: 7];
      rr = '{k, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 4)), 1'b0, bad_parity(k) ? 2'b01 : 2'b00};
      run_row(rr);
      if (rr.err == 2'b00) grant_phase(16, 1'b0);
    end

    // Async reset while WAIT is timing out.
    @(negedge clk);
    gen_never = 1'b1;
    key_req_valid = 1'b1; key_req_key = 64'h0123456789ABCDEF; key_req_encrypt = 1'b0;
    @(negedge clk);
    key_req_valid = 1'b0;
    repeat (EN_CYCLES + 6) @(negedge clk);
    check("wait_not_ready", 64'(key_ready), 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_wait");
    @(negedge clk);
    rst = 1'b0;

    // Async reset in LOAD: gen_key_en must drop before the next clock edge.
    @(negedge clk);
    key_req_valid = 1'b1; key_req_key = 64'h133457799BBCDFF1; key_req_encrypt = 1'b1;
    @(negedge clk);
    key_req_valid = 1'b0;
    check("load_en_high", 64'(gen_key_en), 64'd1);
    #1 rst = 1'b1;
    #1 check_reset_vals("rst_load");
    @(negedge clk);
    rst = 1'b0;
    gen_never = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 64'(key_req_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
